// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes the D-stage instruction into an ALU control code,
// registers it into the E stage and sequences multi-cycle MULT/DIV operations.
//
// Ports:
//   clk, resetn     clock (rising edge) and asynchronous active-low reset
//   instrD, validD  D-stage instruction word and its valid flag
//   stallE, flushE  hazard-unit stall and kill of the E slot
//   alucontrolE     registered ALU control code for the E stage
//   validE          E slot holds a live instruction
//   is_mdE          E-stage instruction is MULT/MULTU/DIV/DIVU
//   md_busy         multi-cycle op in progress (hazard unit stalls D/E)
//   hilo_we         one-cycle pulse when the multi-cycle result is valid
//   ri_excE         reserved-instruction exception for the E slot
module alu_issue_ctrl #(
    parameter int unsigned CTRL_W   = 5,
    parameter int unsigned MULT_LAT = 2,
    parameter int unsigned DIV_LAT  = 33,
    parameter int unsigned CNT_W    = 6
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [31:0]       instrD,
    input  logic              validD,
    input  logic              stallE,
    input  logic              flushE,
    output logic [CTRL_W-1:0] alucontrolE,
    output logic              validE,
    output logic              is_mdE,
    output logic              md_busy,
    output logic              hilo_we,
    output logic              ri_excE
);

    // ALU control encodings (shared with the E-stage datapath)
    localparam logic [CTRL_W-1:0] ALU_FAIL  = CTRL_W'(0);
    localparam logic [CTRL_W-1:0] ALU_ADD   = CTRL_W'(1);
    localparam logic [CTRL_W-1:0] ALU_ADDU  = CTRL_W'(2);
    localparam logic [CTRL_W-1:0] ALU_SUB   = CTRL_W'(3);
    localparam logic [CTRL_W-1:0] ALU_SUBU  = CTRL_W'(4);
    localparam logic [CTRL_W-1:0] ALU_SLT   = CTRL_W'(5);
    localparam logic [CTRL_W-1:0] ALU_SLTU  = CTRL_W'(6);
    localparam logic [CTRL_W-1:0] ALU_AND   = CTRL_W'(7);
    localparam logic [CTRL_W-1:0] ALU_OR    = CTRL_W'(8);
    localparam logic [CTRL_W-1:0] ALU_XOR   = CTRL_W'(9);
    localparam logic [CTRL_W-1:0] ALU_NOR   = CTRL_W'(10);
    localparam logic [CTRL_W-1:0] ALU_SLL   = CTRL_W'(11);
    localparam logic [CTRL_W-1:0] ALU_SRL   = CTRL_W'(12);
    localparam logic [CTRL_W-1:0] ALU_SRA   = CTRL_W'(13);
    localparam logic [CTRL_W-1:0] ALU_SLLV  = CTRL_W'(14);
    localparam logic [CTRL_W-1:0] ALU_SRLV  = CTRL_W'(15);
    localparam logic [CTRL_W-1:0] ALU_SRAV  = CTRL_W'(16);
    localparam logic [CTRL_W-1:0] ALU_LUI   = CTRL_W'(17);
    localparam logic [CTRL_W-1:0] ALU_MEM   = CTRL_W'(18);
    localparam logic [CTRL_W-1:0] ALU_PC8   = CTRL_W'(19);
    localparam logic [CTRL_W-1:0] ALU_MFC0  = CTRL_W'(20);
    localparam logic [CTRL_W-1:0] ALU_MTC0  = CTRL_W'(21);
    localparam logic [CTRL_W-1:0] ALU_MFHI  = CTRL_W'(22);
    localparam logic [CTRL_W-1:0] ALU_MFLO  = CTRL_W'(23);
    localparam logic [CTRL_W-1:0] ALU_MTHI  = CTRL_W'(24);
    localparam logic [CTRL_W-1:0] ALU_MTLO  = CTRL_W'(25);
    localparam logic [CTRL_W-1:0] ALU_MULT  = CTRL_W'(26);
    localparam logic [CTRL_W-1:0] ALU_MULTU = CTRL_W'(27);
    localparam logic [CTRL_W-1:0] ALU_DIV   = CTRL_W'(28);
    localparam logic [CTRL_W-1:0] ALU_DIVU  = CTRL_W'(29);
    localparam logic [CTRL_W-1:0] ALU_NOP   = CTRL_W'(30);

    localparam logic [CNT_W-1:0] MULT_CNT0 = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT0  = CNT_W'(DIV_LAT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2,
        DONE    = 2'd3
    } state_t;

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [5:0] funct;

    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_trap;
    logic              dec_mul;
    logic              dec_div;
    logic              dec_ri;

    logic              load_e;
    logic              start_mul;
    logic              start_div;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              busy_d;
    logic              we_d;

    logic              unused_bits;

    assign op    = instrD[31:26];
    assign rs    = instrD[25:21];
    assign rt    = instrD[20:16];
    assign funct = instrD[5:0];

    // rd, shamt and the immediate are datapath-only fields
    assign unused_bits = ^instrD[15:6];

    // Instruction decode: R-type by funct, everything else by opcode
    always_comb begin
        dec_ctrl = ALU_FAIL;
        case (op)
            6'h00: begin
                case (funct)
                    6'h00:   dec_ctrl = ALU_SLL;
                    6'h02:   dec_ctrl = ALU_SRL;
                    6'h03:   dec_ctrl = ALU_SRA;
                    6'h04:   dec_ctrl = ALU_SLLV;
                    6'h06:   dec_ctrl = ALU_SRLV;
                    6'h07:   dec_ctrl = ALU_SRAV;
                    6'h08:   dec_ctrl = ALU_NOP;
                    6'h09:   dec_ctrl = ALU_PC8;
                    6'h10:   dec_ctrl = ALU_MFHI;
                    6'h11:   dec_ctrl = ALU_MTHI;
                    6'h12:   dec_ctrl = ALU_MFLO;
                    6'h13:   dec_ctrl = ALU_MTLO;
                    6'h18:   dec_ctrl = ALU_MULT;
                    6'h19:   dec_ctrl = ALU_MULTU;
                    6'h1A:   dec_ctrl = ALU_DIV;
                    6'h1B:   dec_ctrl = ALU_DIVU;
                    6'h20:   dec_ctrl = ALU_ADD;
                    6'h21:   dec_ctrl = ALU_ADDU;
                    6'h22:   dec_ctrl = ALU_SUB;
                    6'h23:   dec_ctrl = ALU_SUBU;
                    6'h24:   dec_ctrl = ALU_AND;
                    6'h25:   dec_ctrl = ALU_OR;
                    6'h26:   dec_ctrl = ALU_XOR;
                    6'h27:   dec_ctrl = ALU_NOR;
                    6'h2A:   dec_ctrl = ALU_SLT;
                    6'h2B:   dec_ctrl = ALU_SLTU;
                    default: dec_ctrl = ALU_FAIL;   // includes SYSCALL/BREAK
                endcase
            end
            6'h01: begin
                case (rt)
                    5'h00, 5'h01: dec_ctrl = ALU_NOP;   // BLTZ/BGEZ
                    5'h10, 5'h11: dec_ctrl = ALU_PC8;   // BLTZAL/BGEZAL link
                    default:      dec_ctrl = ALU_FAIL;
                endcase
            end
            6'h02:                       dec_ctrl = ALU_NOP;
            6'h03:                       dec_ctrl = ALU_PC8;
            6'h04, 6'h05, 6'h06, 6'h07:  dec_ctrl = ALU_NOP;
            6'h08:                       dec_ctrl = ALU_ADD;
            6'h09:                       dec_ctrl = ALU_ADDU;
            6'h0A:                       dec_ctrl = ALU_SLT;
            6'h0B:                       dec_ctrl = ALU_SLTU;
            6'h0C:                       dec_ctrl = ALU_AND;
            6'h0D:                       dec_ctrl = ALU_OR;
            6'h0E:                       dec_ctrl = ALU_XOR;
            6'h0F:                       dec_ctrl = ALU_LUI;
            6'h10: begin
                if (rs == 5'h00) begin
                    dec_ctrl = ALU_MFC0;
                end else if (rs == 5'h04) begin
                    dec_ctrl = ALU_MTC0;
                end else if (rs == 5'h10 && funct == 6'h18) begin
                    dec_ctrl = ALU_NOP;                 // ERET
                end else begin
                    dec_ctrl = ALU_FAIL;
                end
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
            6'h28, 6'h29, 6'h2B:         dec_ctrl = ALU_MEM;
            default:                     dec_ctrl = ALU_FAIL;
        endcase
    end

    // SYSCALL/BREAK also decode to FAIL but are traps, not reserved
    assign dec_trap = (op == 6'h00) && (funct == 6'h0C || funct == 6'h0D);
    assign dec_mul  = (op == 6'h00) && (funct == 6'h18 || funct == 6'h19);
    assign dec_div  = (op == 6'h00) && (funct == 6'h1A || funct == 6'h1B);
    assign dec_ri   = (dec_ctrl == ALU_FAIL) && !dec_trap && validD;

    // E register loads only when neither flushed, stalled nor busy
    assign load_e    = !flushE && !stallE && !md_busy;
    assign start_mul = load_e && validD && dec_mul;
    assign start_div = load_e && validD && dec_div;

    // E-stage pipeline register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            alucontrolE <= ALU_FAIL;
            validE      <= 1'b0;
            is_mdE      <= 1'b0;
            ri_excE     <= 1'b0;
        end else if (flushE) begin
            alucontrolE <= ALU_FAIL;
            validE      <= 1'b0;
            is_mdE      <= 1'b0;
            ri_excE     <= 1'b0;
        end else if (load_e) begin
            alucontrolE <= dec_ctrl;
            validE      <= validD;
            is_mdE      <= validD && (dec_mul || dec_div);
            ri_excE     <= dec_ri;
        end
    end

    // Multi-cycle sequencer state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            md_busy <= 1'b0;
            hilo_we <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            md_busy <= busy_d;
            hilo_we <= we_d;
        end
    end

    // Sequencer next state; DONE may start the next op with no idle gap
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        we_d    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start_mul) begin
                    state_d = MUL_RUN;
                    cnt_d   = MULT_CNT0;
                    busy_d  = 1'b1;
                end else if (start_div) begin
                    state_d = DIV_RUN;
                    cnt_d   = DIV_CNT0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            MUL_RUN, DIV_RUN: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    we_d    = 1'b1;
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A flush kills the running op and its pending result
        if (flushE) begin
            state_d = IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
            we_d    = 1'b0;
        end
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Registered successor to the combinational ALU decoder. Decodes the D-stage instruction into an ALU control code and a class tag, and registers them into the E stage.
- Sequences multi-cycle MULT/MULTU/DIV/DIVU operations with a latency counter. Stalls the pipeline while they run and pulses a HI/LO write enable when they finish.
- Flags reserved instructions. Sits between the decode stage and the E-stage ALU/muldiv datapath.

Parameters:
- CTRL_W, 5, width of the ALU control code; encodings come from define_alu_ctrl.vh.
- MULT_LAT, 2, E-stage cycles a MULT/MULTU occupies (>=1).
- DIV_LAT, 33, E-stage cycles a DIV/DIVU occupies (>=1).
- CNT_W, 6, counter width; must satisfy 2^CNT_W > max(MULT_LAT, DIV_LAT).

Ports:
- clk, input, 1, clock, rising edge.
- resetn, input, 1, asynchronous active-low reset.
- instrD, input, 32, D-stage instruction word.
- validD, input, 1, instrD holds a real instruction.
- stallE, input, 1, external stall of the E stage (hazard unit).
- flushE, input, 1, kill the E-stage slot (exception/branch).
- alucontrolE, output, CTRL_W, registered ALU control code.
- validE, output, 1, E slot holds a live instruction.
- is_mdE, output, 1, E-stage instruction is MULT/MULTU/DIV/DIVU.
- md_busy, output, 1, multi-cycle op in progress; the hazard unit stalls D/E on it.
- hilo_we, output, 1, one-cycle pulse when the multi-cycle result is valid.
- ri_excE, output, 1, reserved-instruction exception for the E slot.

Behaviour:
- Reset (resetn=0, async) clears all outputs and state:
  - alucontrolE=SIG_ALU_FAIL code.
  - validE, is_mdE, md_busy, hilo_we, ri_excE = 0.
  - FSM=IDLE, counter=0.
- Decode (combinational, internal), same table as the current decoder:
  - R-type by funct; I/J-type by op.
  - Loads/stores map to MEM.
  - JAL, JALR, BLTZAL and BGEZAL map to PC8.
  - COP0 with rs=0 maps to MFC0.
- ri flag = decoded code is FAIL AND the instruction is not BREAK/SYSCALL AND validD.
- E register update priority, highest first:
  1. flushE: validE=0, ri_excE=0, is_mdE=0, alucontrolE=FAIL. Flush also aborts any running multi-cycle op: FSM→IDLE, md_busy=0, no hilo_we.
  2. stallE or md_busy: hold all E registers.
  3. Otherwise: load the decoded fields; validE=validD.
- FSM states: IDLE, MUL_RUN, DIV_RUN, DONE.
  - IDLE→MUL_RUN when E register loads a valid MULT/MULTU; counter=MULT_LAT-1. The same edge asserts md_busy.
  - IDLE→DIV_RUN likewise for DIV/DIVU; counter=DIV_LAT-1.
  - MUL_RUN/DIV_RUN: decrement counter each cycle. When counter==0 go to DONE. stallE does not pause the counter.
  - DONE: hilo_we=1 for exactly this cycle, md_busy=0, then →IDLE.
  - The E register may load a new instruction on the DONE cycle.
  - Latency: md_busy high for exactly LAT cycles, then hilo_we on the next cycle.
- Latency 1 case (MULT_LAT=1 or DIV_LAT=1): enter RUN with counter=0 and go straight to DONE.
- ri instruction: registered like any other and never starts the FSM.
- A flushed or invalid (validD=0) MULT/DIV never starts the FSM.
- Reset mid-operation: immediate return to IDLE; no hilo_we.
- Back-to-back MULT then DIV: the DIV stays held in D by md_busy and enters E on the DONE cycle's edge. Its DIV_RUN begins with no idle gap.

Test Plan:
- Reset: hold resetn=0 with arbitrary inputs → all outputs 0 and alucontrolE=FAIL; after release with validD=0 → validE stays 0.
- Decode pass-through: ADDU (0x00851021) then LW (0x8C820004), validD=1 → alucontrolE=ADDU then MEM on successive cycles, validE=1, ri_excE=0.
- DIV with DIV_LAT=33: DIV 0x0085001A → md_busy high exactly 33 cycles, hilo_we high 1 cycle, next instruction enters E on the DONE edge.
- Flush abort: MULT 0x00850018, MULT_LAT=4, flushE in the 2nd busy cycle → md_busy drops next cycle, validE=0, hilo_we never asserts.
- Reserved vs trap: opcode 0x3F → ri_excE=1; SYSCALL 0x0000000C → ri_excE=0, alucontrolE=FAIL; MFC0 with rs≠0 (0x40A00000) → ri_excE=1.
- External stall + async reset: stallE held 3 cycles with ADD in E → outputs frozen; resetn pulsed low mid-DIV → immediate IDLE, md_busy=0, no hilo_we.
